// File: rtl/mill_modif_pkg.sv
// mill_modif_pkg: shared types and constants for the Modified Miller encoder.
// The PARITY state only exists when PARITY_GEN_EN is defined.
package mill_modif_pkg;

  localparam int unsigned N_DEF         = 5;
  localparam int unsigned PAUSE_LEN_DEF = 8;
  localparam int unsigned ETU_CLKS      = 1 << N_DEF;
  localparam int unsigned HALF_ETU      = ETU_CLKS / 2;

  // Y = no pause, X = pause in second half, Z = pause at start of ETU
  typedef enum logic [1:0] {
    SEQ_Y,
    SEQ_X,
    SEQ_Z
  } seq_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
`ifdef PARITY_GEN_EN
    ST_PARITY,
`endif
    ST_EOF0,
    ST_EOF1
  } state_e;

  // Miller rule: 1 -> X; 0 -> Z after a 0 (or SOF), Y after a 1
  function automatic seq_e code_bit(input logic b, input logic prev_b);
    if (b) return SEQ_X;
    if (prev_b) return SEQ_Y;
    return SEQ_Z;
  endfunction

endpackage

// File: rtl/mill_modif_enc_if.sv
// mill_modif_enc_if: byte-stream valid/ready bus feeding the encoder.
interface mill_modif_enc_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic [2:0] in_nbits;
  logic       in_ready;

  modport master (output in_data, in_valid, in_last, in_nbits, input in_ready);
  modport slave  (input in_data, in_valid, in_last, in_nbits, output in_ready);

endinterface

// File: rtl/mill_modif_seq_gen.sv
// mill_modif_seq_gen: maps (sequence type, ETU count) to the registered carrier gate.
module mill_modif_seq_gen
  import mill_modif_pkg::*;
#(
  parameter int unsigned N         = N_DEF,
  parameter int unsigned PAUSE_LEN = PAUSE_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst_i,
  input  seq_e         seq_i,
  input  logic [N-1:0] cnt_i,
  output logic         out_data_o
);

  localparam logic [N-1:0] HALF  = N'(1 << (N - 1));
  localparam logic [N-1:0] PLEN  = N'(PAUSE_LEN);
  localparam logic [N-1:0] X_END = HALF + PLEN;

  logic pause_c;

  // Pause window decode for the symbol about to be shown
  always_comb begin
    pause_c = 1'b0;
    case (seq_i)
      SEQ_Z:   pause_c = (cnt_i < PLEN);
      SEQ_X:   pause_c = (cnt_i >= HALF) && (cnt_i < X_END);
      default: pause_c = 1'b0;
    endcase
  end

  // Carrier gate register, carrier on in reset
  always_ff @(posedge clk) begin
    if (rst_i) out_data_o <= 1'b1;
    else       out_data_o <= ~pause_c;
  end

endmodule

// File: rtl/mill_modif_enc.sv
// mill_modif_enc: Modified Miller PCD->PICC encoder (ISO/IEC 14443-A, 106 kb/s).
// Build option: define PARITY_GEN_EN to append odd parity after every full byte.
module mill_modif_enc
  import mill_modif_pkg::*;
#(
  parameter int unsigned N         = N_DEF,
  parameter int unsigned PAUSE_LEN = PAUSE_LEN_DEF
) (
  input  logic            clk,
  input  logic            in_PoR,
  mill_modif_enc_if.slave in_bus,
  output logic            out_data,
  output logic            out_busy,
  output logic            out_done,
  output logic            out_underrun
);

  localparam logic [N-1:0] CNT_MAX = '1;

  state_e       state_q, state_d;
  seq_e         seq_q, seq_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic [3:0]   bits_q, bits_d;
  logic         last_q, last_d;
  logic         prev_q, prev_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         underrun_q, underrun_d;
  logic         in_ready_q, in_ready_d;
`ifdef PARITY_GEN_EN
  logic         par_q, par_d;
  logic         full_q, full_d;
`endif

  logic       sym_end_c;
  logic       next_byte_c;
  logic [3:0] in_bits_c;

  assign sym_end_c = (cnt_q == CNT_MAX);
  assign in_bits_c = (in_bus.in_last && (in_bus.in_nbits != 3'd0)) ? {1'b0, in_bus.in_nbits} : 4'd8;

  // Next-state: symbol sequencing, byte loading, handshake and underrun
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    cnt_d       = busy_q ? (cnt_q + N'(1)) : cnt_q;
    shift_d     = shift_q;
    bits_d      = bits_q;
    last_d      = last_q;
    prev_d      = prev_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    next_byte_c = 1'b0;
`ifdef PARITY_GEN_EN
    par_d       = par_q;
    full_d      = full_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_bus.in_valid) begin
          shift_d = in_bus.in_data;
          bits_d  = in_bits_c;
          last_d  = in_bus.in_last;
`ifdef PARITY_GEN_EN
          par_d   = 1'b1;
          full_d  = !in_bus.in_last || (in_bus.in_nbits == 3'd0);
`endif
          state_d = ST_SOF;
          seq_d   = SEQ_Z;
          cnt_d   = '0;
          prev_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SOF: begin
        if (sym_end_c) begin
          state_d = ST_DATA;
          seq_d   = code_bit(shift_q[0], prev_q);
          prev_d  = shift_q[0];
`ifdef PARITY_GEN_EN
          par_d   = par_q ^ shift_q[0];
`endif
        end
      end
      ST_DATA: begin
        if (sym_end_c) begin
          if (bits_q > 4'd1) begin
            bits_d  = bits_q - 4'd1;
            shift_d = {1'b0, shift_q[7:1]};
            seq_d   = code_bit(shift_q[1], prev_q);
            prev_d  = shift_q[1];
`ifdef PARITY_GEN_EN
            par_d   = par_q ^ shift_q[1];
          end else if (full_q) begin
            state_d = ST_PARITY;
            seq_d   = code_bit(par_q, prev_q);
            prev_d  = par_q;
`endif
          end else begin
            next_byte_c = 1'b1;
          end
        end
      end
`ifdef PARITY_GEN_EN
      ST_PARITY: begin
        if (sym_end_c) next_byte_c = 1'b1;
      end
`endif
      ST_EOF0: begin
        if (sym_end_c) begin
          state_d = ST_EOF1;
          seq_d   = SEQ_Y;
        end
      end
      ST_EOF1: begin
        if (sym_end_c) begin
          state_d = ST_IDLE;
          seq_d   = SEQ_Y;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        seq_d   = SEQ_Y;
        busy_d  = 1'b0;
      end
    endcase

    // End of a byte: take the next one back-to-back, or close the frame
    if (next_byte_c) begin
      if (!last_q && in_bus.in_valid) begin
        shift_d = in_bus.in_data;
        bits_d  = in_bits_c;
        last_d  = in_bus.in_last;
`ifdef PARITY_GEN_EN
        par_d   = 1'b1 ^ in_bus.in_data[0];
        full_d  = !in_bus.in_last || (in_bus.in_nbits == 3'd0);
`endif
        state_d = ST_DATA;
        seq_d   = code_bit(in_bus.in_data[0], prev_q);
        prev_d  = in_bus.in_data[0];
      end else begin
        underrun_d = !last_q;
        state_d    = ST_EOF0;
        seq_d      = code_bit(1'b0, prev_q);
        prev_d     = 1'b0;
      end
    end

`ifdef PARITY_GEN_EN
    in_ready_d = (state_d == ST_IDLE) ||
                 ((state_d == ST_PARITY) && !last_d && (cnt_d == CNT_MAX));
`else
    in_ready_d = (state_d == ST_IDLE) ||
                 ((state_d == ST_DATA) && (bits_d == 4'd1) && !last_d && (cnt_d == CNT_MAX));
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (in_PoR) begin
      state_q    <= ST_IDLE;
      seq_q      <= SEQ_Y;
      cnt_q      <= '0;
      shift_q    <= '0;
      bits_q     <= '0;
      last_q     <= 1'b0;
      prev_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      in_ready_q <= 1'b1;
`ifdef PARITY_GEN_EN
      par_q      <= 1'b0;
      full_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bits_q     <= bits_d;
      last_q     <= last_d;
      prev_q     <= prev_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      in_ready_q <= in_ready_d;
`ifdef PARITY_GEN_EN
      par_q      <= par_d;
      full_q     <= full_d;
`endif
    end
  end

  mill_modif_seq_gen #(
    .N         (N),
    .PAUSE_LEN (PAUSE_LEN)
  ) u_seq_gen (
    .clk        (clk),
    .rst_i      (in_PoR),
    .seq_i      (seq_d),
    .cnt_i      (cnt_d),
    .out_data_o (out_data)
  );

  assign in_bus.in_ready = in_ready_q;
  assign out_busy        = busy_q;
  assign out_done        = done_q;
  assign out_underrun    = underrun_q;

endmodule

// File: tb/tb_mill_modif_enc.sv
// tb_mill_modif_enc: scoreboard bench for mill_modif_enc (N=5, PAUSE_LEN=8).
// Expected symbol strings follow the PARITY_GEN_EN build option.
module tb_mill_modif_enc;

  logic clk = 1'b0;
  logic in_PoR;
  logic out_data, out_busy, out_done, out_underrun;

  mill_modif_enc_if bus ();

  mill_modif_enc dut (
    .clk          (clk),
    .in_PoR       (in_PoR),
    .in_bus       (bus),
    .out_data     (out_data),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_underrun (out_underrun)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  byte exp_sym_q[$];
  int  exp_len_q[$];
  bit  mon_en = 1'b0;
  int  und_cnt = 0;
  int  rdy_cnt = 0;
  int  sym_k = 0;
  int  sym_idx = 0;
  int  busy_clks = 0;
  logic [31:0] low_mask = '0;
  byte sym_got;
  byte sym_exp;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_sym(input int idx, input byte got, input byte exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL symbol[%0d]: got %c expected %c", idx, got, exp);
    end
  endtask

  function automatic byte classify(input logic [31:0] m);
    if (m == 32'h0000_0000) return "Y";
    if (m == 32'h0000_00FF) return "Z";
    if (m == 32'h00FF_0000) return "X";
    return "?";
  endfunction

  // Monitor: rebuild one symbol per 32 busy clocks and score against the queue
  always @(negedge clk) begin
    if (!mon_en) begin
      sym_k     = 0;
      busy_clks = 0;
      low_mask  = '0;
    end else begin
      if (out_underrun) und_cnt++;
      if (out_busy && bus.in_ready) rdy_cnt++;
      if (out_busy) begin
        low_mask[sym_k] = ~out_data;
        sym_k++;
        busy_clks++;
        if (sym_k == 32) begin
          sym_got = classify(low_mask);
          if (exp_sym_q.size() == 0) sym_exp = "-";
          else sym_exp = exp_sym_q.pop_front();
          check_sym(sym_idx, sym_got, sym_exp);
          sym_idx++;
          sym_k    = 0;
          low_mask = '0;
        end
      end
      if (out_done) begin
        if (exp_len_q.size() == 0) check("frame_len_unexpected", busy_clks, -1);
        else check("frame_len", busy_clks, exp_len_q.pop_front() * 32);
        busy_clks = 0;
      end
    end
  end

  task automatic queue_frame(input string s);
    for (int i = 0; i < s.len(); i++) exp_sym_q.push_back(s[i]);
    exp_len_q.push_back(s.len());
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l, input logic [2:0] nb);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_nbits = nb;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_sof(input string name);
    @(negedge clk);
    check({name, "_sof_busy"}, out_busy, 1);
    check({name, "_sof_low"}, out_data, 0);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!out_done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done_seen"}, out_done, 1);
    @(negedge clk);
    check({name, "_done_pulse_len"}, out_done, 0);
  endtask

  int r0, u0, lows;

  initial begin
    in_PoR       = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_nbits = '0;
    repeat (3) @(negedge clk);
    check("rst_out_data", out_data, 1);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", out_busy, 0);
    check("rst_done", out_done, 0);
    check("rst_underrun", out_underrun, 0);
    in_PoR = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // REQA short frame: 7 bits, no parity
    queue_frame("ZZXXYZXYZY");
    r0 = rdy_cnt;
    push_byte(8'h26, 1'b1, 3'd7);
    check_sof("reqa");
    wait_done("reqa");
    check("reqa_ready_pulses", rdy_cnt - r0, 0);

    // Two-byte frame, ready slot only between the bytes
`ifdef PARITY_GEN_EN
    queue_frame("ZXXYZXYZXXYZZZZXYZZZY");
`else
    queue_frame("ZXXYZXYZXYZZZZXYZZY");
`endif
    r0 = rdy_cnt;
    push_byte(8'h93, 1'b0, 3'd0);
    check_sof("sel");
    push_byte(8'h20, 1'b1, 3'd0);
    wait_done("sel");
    check("sel_ready_pulses", rdy_cnt - r0, 1);

    // Underrun after a non-last 0x00
`ifdef PARITY_GEN_EN
    queue_frame("ZZZZZZZZZXYY");
`else
    queue_frame("ZZZZZZZZZZY");
`endif
    r0 = rdy_cnt;
    u0 = und_cnt;
    push_byte(8'h00, 1'b0, 3'd0);
    check_sof("und");
    wait_done("und");
    check("und_pulses", und_cnt - u0, 1);
    check("und_ready_pulses", rdy_cnt - r0, 1);

    // All-ones last byte
`ifdef PARITY_GEN_EN
    queue_frame("ZXXXXXXXXXYY");
`else
    queue_frame("ZXXXXXXXXYY");
`endif
    push_byte(8'hFF, 1'b1, 3'd0);
    check_sof("ff");
    wait_done("ff");

    // Reset asserted inside the first X pause
    mon_en = 1'b0;
    push_byte(8'hFF, 1'b1, 3'd0);
    repeat (51) @(negedge clk);
    check("por_in_x_pause", out_data, 0);
    in_PoR = 1'b1;
    @(negedge clk);
    check("por_out_data", out_data, 1);
    check("por_busy", out_busy, 0);
    check("por_in_ready", bus.in_ready, 1);
    check("por_done", out_done, 0);
    in_PoR = 1'b0;
    lows = 0;
    repeat (64) begin
      @(negedge clk);
      if (!out_data || out_busy) lows++;
    end
    check("por_quiet_after", lows, 0);

    // Recovery after reset
    mon_en = 1'b1;
    queue_frame("ZZXXYZXYZY");
    push_byte(8'h26, 1'b1, 3'd7);
    check_sof("recov");
    wait_done("recov");

    repeat (4) @(negedge clk);
    check("sym_queue_empty", exp_sym_q.size(), 0);
    check("len_queue_empty", exp_len_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
